ex_alu_btb: RTL and testbench

Execute-stage datapath slice for the five-stage MIPS pipeline with 1-bit branch prediction. It combines the ALU-control decoder, the 32-bit ALU, and a direct-mapped branch target table. The table is looked up with PC+4 in fetch and is written when a branch resolves. The ALU path is purely combinational; the table is the only sequential part.

---
 rtl/ex_pkg.sv | 24 ++
 rtl/btb_1bit.sv | 66 ++++++
 rtl/ex_alu_btb.sv | 81 ++++++++
 tb/tb_ex_alu_btb.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/ex_pkg.sv
// Shared encodings for the execute-stage slice: ALU control codes, aluop classes
// and the R-type funct values the decoder recognises.
package ex_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_ZERO  = 2'b11;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_NOR = 6'b100111;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

endpackage

// File: rtl/btb_1bit.sv
// Direct-mapped branch target table with a 1-bit prediction per entry.
// Lookup is combinational; writes commit on the rising clock edge with no bypass.
module btb_1bit #(
  parameter int unsigned ENTRIES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc4_i,
  output logic        hit_o,
  output logic        pred_o,
  output logic [31:0] bdest_o,
  input  logic        wrt_i,
  input  logic        wrp_i,
  input  logic [31:0] pc4_wr_i,
  input  logic [31:0] bdest_in_i,
  input  logic        pin_i
);

  localparam int unsigned IDX  = $clog2(ENTRIES);
  localparam int unsigned TagW = 30 - IDX;

  logic            valid_q [ENTRIES];
  logic [TagW-1:0] tag_q   [ENTRIES];
  logic [31:0]     tgt_q   [ENTRIES];
  logic            pred_q  [ENTRIES];

  logic [IDX-1:0]  ridx, widx;
  logic [TagW-1:0] rtag, wtag;
  logic            wr_match;

  // Word-aligned PCs: the low two bits never take part in index or tag.
  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^{pc4_i[1:0], pc4_wr_i[1:0]};

  assign ridx = pc4_i[IDX+1:2];
  assign rtag = pc4_i[31:IDX+2];
  assign widx = pc4_wr_i[IDX+1:2];
  assign wtag = pc4_wr_i[31:IDX+2];

  assign wr_match = valid_q[widx] && (tag_q[widx] == wtag);

  always_comb begin
    hit_o   = valid_q[ridx] && (tag_q[ridx] == rtag);
    pred_o  = hit_o & pred_q[ridx];
    bdest_o = hit_o ? tgt_q[ridx] : 32'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        tgt_q[i]   <= '0;
        pred_q[i]  <= 1'b0;
      end
    end else if (wrt_i) begin
      valid_q[widx] <= 1'b1;
      tag_q[widx]   <= wtag;
      tgt_q[widx]   <= bdest_in_i;
      pred_q[widx]  <= pin_i;
    end else if (wrp_i && wr_match) begin
      pred_q[widx] <= pin_i;
    end
  end

endmodule

// File: rtl/ex_alu_btb.sv
// Execute-stage slice: ALU-control decoder and 32-bit ALU (combinational) plus the
// branch target table looked up with the fetch-stage PC+4.
module ex_alu_btb
  import ex_pkg::*;
#(
  parameter int unsigned ENTRIES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  funct_i,
  input  logic [1:0]  aluop_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [3:0]  aluctl_o,
  output logic [31:0] alu_out_o,
  output logic        zero_o,
  input  logic [31:0] pc4_i,
  output logic        hit_o,
  output logic        pred_o,
  output logic [31:0] bdest_o,
  input  logic        wrt_i,
  input  logic        wrp_i,
  input  logic [31:0] pc4_wr_i,
  input  logic [31:0] bdest_in_i,
  input  logic        pin_i
);

  always_comb begin
    aluctl_o = ALU_AND;
    unique case (aluop_i)
      ALUOP_ADD: aluctl_o = ALU_ADD;
      ALUOP_SUB: aluctl_o = ALU_SUB;
      ALUOP_RTYPE: begin
        case (funct_i)
          FUNCT_ADD: aluctl_o = ALU_ADD;
          FUNCT_SUB: aluctl_o = ALU_SUB;
          FUNCT_AND: aluctl_o = ALU_AND;
          FUNCT_OR:  aluctl_o = ALU_OR;
          FUNCT_NOR: aluctl_o = ALU_NOR;
          FUNCT_SLT: aluctl_o = ALU_SLT;
          default:   aluctl_o = ALU_AND;
        endcase
      end
      ALUOP_ZERO: aluctl_o = ALU_AND;
      default:    aluctl_o = ALU_AND;
    endcase
  end

  // Add and sub wrap modulo 2^32; no overflow is reported.
  always_comb begin
    alu_out_o = 32'd0;
    case (aluctl_o)
      ALU_AND: alu_out_o = a_i & b_i;
      ALU_OR:  alu_out_o = a_i | b_i;
      ALU_ADD: alu_out_o = a_i + b_i;
      ALU_SUB: alu_out_o = a_i - b_i;
      ALU_SLT: alu_out_o = {31'd0, $signed(a_i) < $signed(b_i)};
      ALU_NOR: alu_out_o = ~(a_i | b_i);
      default: alu_out_o = 32'd0;
    endcase
  end

  assign zero_o = (alu_out_o == 32'd0);

  btb_1bit #(
    .ENTRIES(ENTRIES)
  ) u_btb (
    .clk        (clk),
    .rst_n      (rst_n),
    .pc4_i      (pc4_i),
    .hit_o      (hit_o),
    .pred_o     (pred_o),
    .bdest_o    (bdest_o),
    .wrt_i      (wrt_i),
    .wrp_i      (wrp_i),
    .pc4_wr_i   (pc4_wr_i),
    .bdest_in_i (bdest_in_i),
    .pin_i      (pin_i)
  );

endmodule

// File: tb/tb_ex_alu_btb.sv
// Bench for ex_alu_btb: table-driven decoder/ALU vectors plus directed sequences
// for branch-table allocation, update, conflict replacement and mid-run reset.
module tb_ex_alu_btb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  funct;
  logic [1:0]  aluop;
  logic [31:0] a, b;
  logic [3:0]  aluctl;
  logic [31:0] alu_out;
  logic        zero;
  logic [31:0] pc4;
  logic        hit, pred;
  logic [31:0] bdest;
  logic        wrt, wrp;
  logic [31:0] pc4_wr, bdest_in;
  logic        pin;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  ex_alu_btb #(
    .ENTRIES(16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .funct_i    (funct),
    .aluop_i    (aluop),
    .a_i        (a),
    .b_i        (b),
    .aluctl_o   (aluctl),
    .alu_out_o  (alu_out),
    .zero_o     (zero),
    .pc4_i      (pc4),
    .hit_o      (hit),
    .pred_o     (pred),
    .bdest_o    (bdest),
    .wrt_i      (wrt),
    .wrp_i      (wrp),
    .pc4_wr_i   (pc4_wr),
    .bdest_in_i (bdest_in),
    .pin_i      (pin)
  );

  typedef struct {
    logic [1:0]  aluop;
    logic [5:0]  funct;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  ctl;
    logic [31:0] res;
    logic        z;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_alu(input int i);
    aluop = vecs[i].aluop;
    funct = vecs[i].funct;
    a     = vecs[i].a;
    b     = vecs[i].b;
    #1;
    chk($sformatf("vec%0d aluctl", i), {28'd0, aluctl}, {28'd0, vecs[i].ctl});
    chk($sformatf("vec%0d alu_out", i), alu_out, vecs[i].res);
    chk($sformatf("vec%0d zero", i), {31'd0, zero}, {31'd0, vecs[i].z});
  endtask

  // Each call advances 1 time unit; callers keep at most two per half-cycle.
  task automatic lookup(input logic [31:0] pc, input logic eh, input logic ep,
                        input logic [31:0] eb, input string nm);
    pc4 = pc;
    #1;
    chk({nm, " hit"}, {31'd0, hit}, {31'd0, eh});
    chk({nm, " pred"}, {31'd0, pred}, {31'd0, ep});
    chk({nm, " bdest"}, bdest, eb);
  endtask

  initial begin
    funct = '0; aluop = '0; a = '0; b = '0; pc4 = '0;
    wrt = 1'b0; wrp = 1'b0; pc4_wr = '0; bdest_in = '0; pin = 1'b0;

    vecs[0]  = '{2'b10, 6'b100010, 32'd5,        32'd5,        4'b0110, 32'd0,        1'b1};
    vecs[1]  = '{2'b10, 6'b101010, 32'hFFFFFFFF, 32'd1,        4'b0111, 32'd1,        1'b0};
    vecs[2]  = '{2'b00, 6'b000000, 32'h7FFFFFFF, 32'd1,        4'b0010, 32'h80000000, 1'b0};
    vecs[3]  = '{2'b01, 6'b111111, 32'd3,        32'd5,        4'b0110, 32'hFFFFFFFE, 1'b0};
    vecs[4]  = '{2'b11, 6'b100000, 32'd3,        32'd5,        4'b0000, 32'd1,        1'b0};
    vecs[5]  = '{2'b10, 6'b100000, 32'd10,       32'd20,       4'b0010, 32'd30,       1'b0};
    vecs[6]  = '{2'b10, 6'b100100, 32'h0000F0F0, 32'h0000FF00, 4'b0000, 32'h0000F000, 1'b0};
    vecs[7]  = '{2'b10, 6'b100101, 32'h0000F0F0, 32'h00000F0F, 4'b0001, 32'h0000FFFF, 1'b0};
    vecs[8]  = '{2'b10, 6'b100111, 32'd0,        32'd0,        4'b1100, 32'hFFFFFFFF, 1'b0};
    vecs[9]  = '{2'b10, 6'b101010, 32'd1,        32'hFFFFFFFF, 4'b0111, 32'd0,        1'b1};
    vecs[10] = '{2'b10, 6'b111111, 32'd6,        32'd3,        4'b0000, 32'd2,        1'b0};
    vecs[11] = '{2'b10, 6'b100010, 32'd0,        32'd1,        4'b0110, 32'hFFFFFFFF, 1'b0};

    // Reset state, with the ALU still live during reset.
    #12;
    lookup(32'h14, 1'b0, 1'b0, 32'd0, "reset");
    check_alu(2);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check_alu(i);
    end

    // Allocation; the write cycle itself still sees the old contents.
    @(negedge clk);
    lookup(32'h14, 1'b0, 1'b0, 32'd0, "alloc pre");
    @(negedge clk);
    wrt = 1'b1; pc4_wr = 32'h14; bdest_in = 32'h40; pin = 1'b1;
    lookup(32'h14, 1'b0, 1'b0, 32'd0, "alloc same");
    @(negedge clk);
    wrt = 1'b0;
    lookup(32'h14, 1'b1, 1'b1, 32'h40, "alloc");

    // Prediction update on matching tag, then on an alias with another tag.
    wrp = 1'b1; pin = 1'b0; pc4_wr = 32'h14;
    @(negedge clk);
    wrp = 1'b0;
    lookup(32'h14, 1'b1, 1'b0, 32'h40, "wrp");
    wrp = 1'b1; pin = 1'b1; pc4_wr = 32'h54;
    @(negedge clk);
    wrp = 1'b0;
    lookup(32'h14, 1'b1, 1'b0, 32'h40, "alias wrp");
    lookup(32'h54, 1'b0, 1'b0, 32'd0, "alias miss");

    // Conflict replacement at index 5.
    @(negedge clk);
    wrt = 1'b1; pc4_wr = 32'h54; bdest_in = 32'h80; pin = 1'b1;
    lookup(32'h14, 1'b1, 1'b0, 32'h40, "conflict same old");
    lookup(32'h54, 1'b0, 1'b0, 32'd0, "conflict same new");
    @(negedge clk);
    wrt = 1'b0;
    lookup(32'h14, 1'b0, 1'b0, 32'd0, "evicted");
    lookup(32'h54, 1'b1, 1'b1, 32'h80, "replaced");

    wrt = 1'b1; pc4_wr = 32'h108; bdest_in = 32'h200; pin = 1'b0;
    @(negedge clk);
    wrt = 1'b0;
    lookup(32'h108, 1'b1, 1'b0, 32'h200, "second");
    lookup(32'h54, 1'b1, 1'b1, 32'h80, "second keep");

    // Mid-run asynchronous reset between edges.
    rst_n = 1'b0;
    lookup(32'h54, 1'b0, 1'b0, 32'd0, "async reset");
    @(negedge clk);
    lookup(32'h108, 1'b0, 1'b0, 32'd0, "reset clears");
    rst_n = 1'b1;

    // wrp alone on an invalid entry does nothing.
    @(negedge clk);
    wrp = 1'b1; pin = 1'b1; pc4_wr = 32'h54;
    @(negedge clk);
    wrp = 1'b0;
    lookup(32'h54, 1'b0, 1'b0, 32'd0, "wrp invalid");

    // wrt and wrp together: full write wins.
    wrt = 1'b1; wrp = 1'b1; pc4_wr = 32'h54; bdest_in = 32'h99; pin = 1'b1;
    @(negedge clk);
    wrt = 1'b0; wrp = 1'b0;
    lookup(32'h54, 1'b1, 1'b1, 32'h99, "wrt+wrp");
    wrt = 1'b1; wrp = 1'b1; pc4_wr = 32'h54; bdest_in = 32'hAA; pin = 1'b0;
    @(negedge clk);
    wrt = 1'b0; wrp = 1'b0;
    lookup(32'h54, 1'b1, 1'b0, 32'hAA, "wrt+wrp pin0");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
